// File: rtl/int_ctrl_if.sv
// Bus interface between the system bridge and the interrupt controller register file.
interface int_ctrl_if;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output addr, output byteen, output wdata, input rdata);
  modport slave  (input sel, input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller feeding CP0 HWInt: per-source pending latch, mask, level/edge mode,
// write-1-to-clear acknowledge and a highest-source ID register.
module int_ctrl #(
  parameter int unsigned NSRC    = 3,
  parameter int unsigned EXT_SRC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  int_ctrl_if.slave       bus,
  output logic [5:0]      hwint,
  output logic            ext_ack
);

  localparam logic [1:0] AddrPend = 2'd0;
  localparam logic [1:0] AddrMask = 2'd1;
  localparam logic [1:0] AddrEdge = 2'd2;
  localparam logic [1:0] AddrId   = 2'd3;

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] irq_q;
  logic [5:0]      hwint_d;
  logic            ext_ack_d;
  logic            wr_en, wr_pend, wr_mask, wr_edge;
  logic [NSRC-1:0] wbits, pend_masked;
  logic [2:0]      id;
  logic            unused_wdata;

  assign wr_en   = bus.sel && (bus.byteen != 4'b0000);
  assign wr_pend = wr_en && (bus.addr == AddrPend);
  assign wr_mask = wr_en && (bus.addr == AddrMask);
  assign wr_edge = wr_en && (bus.addr == AddrEdge);
  assign wbits   = bus.wdata[NSRC-1:0];

  assign unused_wdata = ^bus.wdata[31:NSRC];

  assign mask_d = wr_mask ? wbits : mask_q;
  assign edge_d = wr_edge ? wbits : edge_q;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NSRC; i++) begin
      if (edge_d[i] != edge_q[i]) begin
        // A mode switch discards whatever was latched under the old mode.
        pend_d[i] = 1'b0;
      end else if (!edge_q[i]) begin
        pend_d[i] = irq_in[i];
      end else begin
        // Set beats a simultaneous clear.
        pend_d[i] = (irq_in[i] & ~irq_q[i]) | (pend_q[i] & ~(wr_pend & wbits[i]));
      end
    end
  end

  always_comb begin
    hwint_d = '0;
    hwint_d[NSRC-1:0] = pend_d & mask_d;
  end

  assign ext_ack_d = wr_pend & wbits[EXT_SRC] & pend_q[EXT_SRC];

  assign pend_masked = pend_q & mask_q;

  always_comb begin
    id = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend_masked[i]) begin
        id = 3'(i + 1);
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      unique case (bus.addr)
        AddrPend: bus.rdata = 32'(pend_q);
        AddrMask: bus.rdata = 32'(mask_q);
        AddrEdge: bus.rdata = 32'(edge_q);
        AddrId:   bus.rdata = 32'(id);
        default:  bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      irq_q   <= '0;
      hwint   <= '0;
      ext_ack <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      irq_q   <= irq_in;
      hwint   <= hwint_d;
      ext_ack <= ext_ack_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, level/edge pending, W1C and ext_ack, ID priority,
// mode switch and asynchronous mid-run reset.
module tb_int_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] irq_in;
  logic [5:0] hwint;
  logic       ext_ack;
  int         n_checks;
  int         n_fail;

  int_ctrl_if bus ();

  int_ctrl #(
    .NSRC    (3),
    .EXT_SRC (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .bus     (bus.slave),
    .hwint   (hwint),
    .ext_ack (ext_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.sel    = 1'b1;
    bus.addr   = a;
    bus.byteen = 4'h0;
    #1;
    chk(tag, bus.rdata, exp);
    bus.sel = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel    = 1'b1;
    bus.addr   = a;
    bus.byteen = 4'hf;
    bus.wdata  = d;
    step();
    bus.sel    = 1'b0;
    bus.byteen = 4'h0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    bus.sel    = 1'b0;
    bus.addr   = 2'd0;
    bus.byteen = 4'h0;
    bus.wdata  = '0;
    irq_in     = 3'b111;
    reset      = 1'b0;

    // Reset held with all sources high
    step();
    step();
    rd(2'd0, 32'd0, "rst_pend");
    rd(2'd1, 32'd0, "rst_mask");
    rd(2'd2, 32'd0, "rst_edge");
    rd(2'd3, 32'd0, "rst_id");
    chk("rst_hwint", 32'(hwint), 32'd0);
    chk("rst_ext_ack", 32'(ext_ack), 32'd0);

    reset = 1'b1;
    step();
    rd(2'd0, 32'd7, "post_rst_pend");
    chk("post_rst_hwint", 32'(hwint), 32'd0);
    rd(2'd3, 32'd0, "post_rst_id_masked");

    // Level routing on source 0
    irq_in = 3'b001;
    step();
    wr(2'd1, 32'd1);
    chk("lvl_hwint_on", 32'(hwint), 32'd1);
    rd(2'd3, 32'd1, "lvl_id");
    irq_in = 3'b000;
    step();
    chk("lvl_hwint_off", 32'(hwint), 32'd0);
    rd(2'd0, 32'd0, "lvl_pend_off");
    irq_in = 3'b001;
    step();
    wr(2'd0, 32'd1);
    rd(2'd0, 32'd1, "lvl_w1c_override");
    chk("lvl_w1c_hwint", 32'(hwint), 32'd1);
    chk("lvl_w1c_no_ack", 32'(ext_ack), 32'd0);

    // Edge mode on source 2 and ext_ack
    irq_in = 3'b000;
    step();
    wr(2'd2, 32'h4);
    wr(2'd1, 32'h4);
    chk("edge_hwint_idle", 32'(hwint), 32'd0);
    irq_in = 3'b100;
    step();
    irq_in = 3'b000;
    step();
    rd(2'd0, 32'h4, "edge_pend_latched");
    chk("edge_hwint", 32'(hwint), 32'h4);
    irq_in = 3'b100;
    step();
    wr(2'd0, 32'h4);
    chk("edge_ext_ack", 32'(ext_ack), 32'd1);
    rd(2'd0, 32'd0, "edge_w1c");
    chk("edge_w1c_hwint", 32'(hwint), 32'd0);
    step();
    chk("edge_ext_ack_drop", 32'(ext_ack), 32'd0);
    rd(2'd0, 32'd0, "edge_held_no_reset");

    // Set and clear in the same cycle
    irq_in = 3'b000;
    step();
    irq_in = 3'b100;
    wr(2'd0, 32'h4);
    rd(2'd0, 32'h4, "collide_pend");
    chk("collide_no_ack", 32'(ext_ack), 32'd0);

    // Priority / ID
    irq_in = 3'b011;
    wr(2'd2, 32'd0);
    rd(2'd0, 32'h3, "modeclr_pend");
    wr(2'd1, 32'h7);
    rd(2'd3, 32'd2, "id_011");
    chk("id_011_hwint", 32'(hwint), 32'h3);
    irq_in = 3'b111;
    step();
    rd(2'd3, 32'd3, "id_111");
    chk("id_111_hwint", 32'(hwint), 32'h7);
    wr(2'd1, 32'd0);
    rd(2'd3, 32'd0, "id_masked");
    chk("mask_off_hwint", 32'(hwint), 32'd0);

    // Mode switch clears only the changed bit
    wr(2'd2, 32'h2);
    rd(2'd0, 32'h5, "modesw_pend");
    rd(2'd2, 32'h2, "modesw_edge_rb");

    // Read during write returns the old value
    bus.sel    = 1'b1;
    bus.addr   = 2'd1;
    bus.byteen = 4'hf;
    bus.wdata  = 32'h7;
    #1;
    chk("rdw_old_mask", bus.rdata, 32'd0);
    step();
    bus.sel    = 1'b0;
    bus.byteen = 4'h0;
    chk("mask_all_hwint", 32'(hwint), 32'h5);
    rd(2'd1, 32'h7, "mask_rb");

    // Level W1C on the external source still acknowledges
    wr(2'd0, 32'h4);
    chk("lvl_ext_ack", 32'(ext_ack), 32'd1);
    rd(2'd0, 32'h5, "lvl_ext_pend_kept");

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("async_hwint", 32'(hwint), 32'd0);
    chk("async_ext_ack", 32'(ext_ack), 32'd0);
    rd(2'd0, 32'd0, "async_pend");
    rd(2'd1, 32'd0, "async_mask");
    rd(2'd2, 32'd0, "async_edge");
    step();
    reset = 1'b1;
    step();
    rd(2'd0, 32'h7, "rerelease_pend");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller between the interrupt sources and the CP0 HWInt inputs of the pipelined MIPS core.
- Sources are {external interrupt, Timer1 IRQ, Timer0 IRQ}.
- Per source it provides pending latching, masking, level/edge mode selection, write-1-to-clear acknowledge and a priority ID register.
- It is reached through the system bridge at 0x7F30–0x7F3F. Decode of the base address happens outside this block.

Parameters:
- NSRC, 3, number of interrupt sources (1..6); source i drives hwint[i].
- EXT_SRC, 2, index of the external-interrupt source; clearing its pending bit pulses ext_ack.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- irq_in  in  NSRC  raw source requests, synchronous to clk.
- sel  in  1  bridge select; high when the CPU data address lies in 0x7F30–0x7F3F.
- addr  in  2  word offset, taken from address bits [3:2].
- byteen  in  4  CPU byte-write enables; a write occurs when sel=1 and byteen≠0.
- wdata  in  32  write data; only bits [NSRC-1:0] are used.
- rdata  out  32  read data, combinational from registered state.
- hwint  out  6  to CP0 Cause.IP[7:2]; bits NSRC..5 are tied to 0.
- ext_ack  out  1  one-cycle pulse when the external source's pending bit is cleared by software.

Behaviour:
- Register map by addr:
  - 0 PEND: read-only view, write-1-to-clear.
  - 1 MASK: read/write.
  - 2 EDGE: read/write; 1 = edge mode, 0 = level mode.
  - 3 ID: read-only; writes are ignored.
- Unused read bits return 0. When sel=0, rdata=0.
- Reset (reset=0, asynchronous): pend, mask, edge and irq_q all clear to 0; hwint=0; ext_ack=0.
- irq_q holds irq_in delayed by one clock.
- Level mode (edge[i]=0):
  - pend[i] <= irq_in[i] every cycle.
  - A W1C write is overridden whenever irq_in[i]=1 in that cycle.
  - Latency from irq_in to pend is 1 cycle.
- Edge mode (edge[i]=1):
  - Set condition: irq_in[i] & ~irq_q[i] (rising edge), which sets pend[i].
  - A W1C write with wdata[i]=1 clears pend[i].
  - When a set and a clear happen in the same cycle, set wins and pend stays 1.
  - A held-high input does not re-set pend after it is cleared.
- EDGE write: every bit whose mode changes has its pend cleared in the same cycle. Bits whose mode is unchanged are not affected.
- Registered outputs:
  - hwint[i] <= pend_next[i] & mask_next[i].
  - An MASK write therefore takes effect on hwint at the same edge it commits.
- ID: the index+1 of the highest-numbered bit set in pend & mask; 0 when none is set. Example: pend&mask = 3'b011 gives ID=2.
- ext_ack: registered; equals 1 in the cycle after a PEND write with wdata[EXT_SRC]=1 and pend[EXT_SRC]=1. This holds in both modes.
- A read and a write to the same register in the same cycle: rdata shows the old value.
- Reset asserted mid-operation: all state clears immediately, with no dependence on clk. After reset deasserts, a source that is already high:
  - in level mode, appears in pend after 1 cycle;
  - in edge mode, is not captured until it goes low and then high again. This is because edge mode is 0 after reset, and irq_q must be re-primed.

Test Plan:
- Reset: reset=0 while irq_in=3'b111 → rdata for every addr is 0, hwint=0; release reset with mask=0 → PEND reads 3'b111 one cycle later, hwint stays 0.
- Level routing: write MASK=3'b001, irq_in[0]=1 → hwint=6'b000001 after 1 edge, ID=1. Drop irq_in[0] → hwint=0 after 1 edge. A W1C while the input is still high leaves pend[0]=1.
- Edge and ext_ack: write EDGE=3'b100, MASK=3'b100. Pulse irq_in[2] for 1 cycle → PEND=3'b100, hwint[2]=1. Hold irq_in[2] high, write PEND=3'b100 → pend[2]=0, ext_ack=1 for exactly one cycle, no re-set.
- Set/clear collision: in edge mode, rising edge on irq_in[2] in the same cycle as a W1C of bit 2 → pend[2]=1, ext_ack=0 (pend was 0 before the write).
- Priority/ID: MASK=3'b111 with pend=3'b011 → ID=2; then pend=3'b111 → ID=3; then MASK=3'b000 → ID=0, hwint=0 on the same edge.
- Mode switch and mid-run reset: with pend[1]=1 in level mode, write EDGE=3'b010 → pend[1]=0. Assert reset between clock edges → all outputs go to 0 without waiting for a clock edge.
